// File: rtl/serv_dbus_ctrl.sv
// serv_dbus_ctrl: data-bus sequencer between the core's memory-op control
// and the Wishbone data port. Issues one Wishbone cycle per aligned request,
// flags misaligned requests without touching the bus, and hands the read
// word to the buffer register together with a one-cycle load strobe.
// Optional feature: define SERV_DBUS_TIMEOUT_EN to abort a bus cycle that
// gets no ack within TIMEOUT_CYCLES cycles (reported on o_err).
module serv_dbus_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_wdat,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic [31:0] o_rdat,
    output logic        o_load,
    output logic        o_ack,
    output logic        o_misalign,
    output logic        o_busy,
    output logic        o_err
);

    typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rdat_q, rdat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic        load_q, load_d;
    logic        ack_q, ack_d;
    logic        mis_q, mis_d;
    logic        err_d;
    logic        timeout;
    logic        misaligned;
    logic [3:0]  sel_calc;

    // Alignment check and byte-lane select for the incoming request
    always_comb begin
        misaligned = ((i_size == 2'd1) && i_adr[0]) ||
                     (i_size[1] && (i_adr[1:0] != 2'b00));
        case (i_size)
            2'd0:    sel_calc = 4'b0001 << i_adr[1:0];
            2'd1:    sel_calc = i_adr[1] ? 4'b1100 : 4'b0011;
            default: sel_calc = 4'b1111;
        endcase
    end

`ifdef SERV_DBUS_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        err_q;

    assign timeout = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign o_err   = err_q;

    // Ack-wait counter: cleared on entry to BUS, counts cycles without ack
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE)
            cnt_d = '0;
        else if (!i_wb_ack && !timeout)
            cnt_d = cnt_q + 16'd1;
    end

    // Timeout counter and error pulse registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign timeout = 1'b0;
    assign o_err   = 1'b0;
`endif

    // Next-state and registered-output logic for the IDLE/BUS sequencer
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        rdat_d  = rdat_q;
        load_d  = 1'b0;
        ack_d   = 1'b0;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // The ack/misalign guards keep a still-held i_req from
                // being taken again while the core sees the previous result.
                if (i_req && !ack_q && !mis_q) begin
                    if (misaligned) begin
                        mis_d = 1'b1;
                    end else begin
                        adr_d   = {i_adr[31:2], 2'b00};
                        dat_d   = i_wdat;
                        sel_d   = sel_calc;
                        we_d    = i_we;
                        cyc_d   = 1'b1;
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                if (i_wb_ack) begin
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                    ack_d   = 1'b1;
                    if (!we_q) begin
                        rdat_d = i_wb_rdt;
                        load_d = 1'b1;
                    end
                end else if (timeout) begin
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset clears everything
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            rdat_q  <= '0;
            load_q  <= 1'b0;
            ack_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            rdat_q  <= rdat_d;
            load_q  <= load_d;
            ack_q   <= ack_d;
            mis_q   <= mis_d;
        end
    end

    assign o_wb_adr   = adr_q;
    assign o_wb_dat   = dat_q;
    assign o_wb_sel   = sel_q;
    assign o_wb_we    = we_q;
    assign o_wb_cyc   = cyc_q;
    assign o_rdat     = rdat_q;
    assign o_load     = load_q;
    assign o_ack      = ack_q;
    assign o_misalign = mis_q;
    assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_serv_dbus_ctrl.sv
// Self-checking bench for serv_dbus_ctrl: directed scenarios plus random
// transactions checked against a byte-count based reference model.
module tb_serv_dbus_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [1:0]  i_size = 2'd0;
    logic [31:0] i_adr = '0;
    logic [31:0] i_wdat = '0;
    logic [31:0] o_wb_adr, o_wb_dat, o_rdat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we, o_wb_cyc, o_load, o_ack, o_misalign, o_busy, o_err;
    logic [31:0] i_wb_rdt = '0;
    logic        i_wb_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rdat = '0;

    serv_dbus_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we),
        .i_size(i_size), .i_adr(i_adr), .i_wdat(i_wdat),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc), .i_wb_rdt(i_wb_rdt),
        .i_wb_ack(i_wb_ack), .o_rdat(o_rdat), .o_load(o_load), .o_ack(o_ack),
        .o_misalign(o_misalign), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Reference model: access width in bytes, alignment, lane mask
    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
    endfunction

    function automatic bit ref_mis(input logic [1:0] s, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(s)) != 0;
    endfunction

    function automatic logic [3:0] ref_sel(input logic [1:0] s, input logic [31:0] a);
        int mask;
        mask = ((1 << nbytes(s)) - 1) << int'(a[1:0]);
        return mask[3:0];
    endfunction

    task automatic run_xfer(input bit we, input logic [1:0] size, input logic [31:0] adr,
                            input logic [31:0] wdat, input logic [31:0] rdt, input int dly);
        logic [31:0] eadr;
        eadr = adr & 32'hFFFF_FFFC;
        i_req = 1'b1; i_we = we; i_size = size; i_adr = adr; i_wdat = wdat;
        tick;
        i_req = 1'b0; i_adr = $urandom; i_wdat = $urandom; i_we = ~we;
        checks++;
        if (o_wb_cyc !== 1'b1 || o_busy !== 1'b1) begin
            errors++; $display("FAIL cyc_rise: cyc=%b busy=%b exp 1/1", o_wb_cyc, o_busy);
        end
        checks++;
        if (o_wb_adr !== eadr || o_wb_sel !== ref_sel(size, adr) || o_wb_we !== we) begin
            errors++; $display("FAIL bus_req: adr=%h sel=%b we=%b exp %h %b %b",
                               o_wb_adr, o_wb_sel, o_wb_we, eadr, ref_sel(size, adr), we);
        end
        checks++;
        if (we && o_wb_dat !== wdat) begin
            errors++; $display("FAIL bus_dat: got %h exp %h", o_wb_dat, wdat);
        end
        for (int k = 0; k < dly; k++) begin
            tick;
            checks++;
            if (o_wb_cyc !== 1'b1 || o_ack !== 1'b0 || o_wb_adr !== eadr ||
                o_wb_sel !== ref_sel(size, adr)) begin
                errors++; $display("FAIL bus_hold: cyc=%b ack=%b adr=%h sel=%b exp 1 0 %h %b",
                                   o_wb_cyc, o_ack, o_wb_adr, o_wb_sel, eadr, ref_sel(size, adr));
            end
        end
        i_wb_ack = 1'b1; i_wb_rdt = rdt;
        tick;
        i_wb_ack = 1'b0; i_wb_rdt = $urandom;
        if (!we) exp_rdat = rdt;
        checks++;
        if (o_ack !== 1'b1 || o_load !== !we || o_err !== 1'b0 || o_wb_cyc !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL done: ack=%b load=%b err=%b cyc=%b busy=%b exp 1 %b 0 0 0",
                               o_ack, o_load, o_err, o_wb_cyc, o_busy, !we);
        end
        checks++;
        if (o_rdat !== exp_rdat) begin
            errors++; $display("FAIL rdat: got %h exp %h", o_rdat, exp_rdat);
        end
        tick;
        checks++;
        if (o_ack !== 1'b0 || o_load !== 1'b0 || o_wb_cyc !== 1'b0 || o_rdat !== exp_rdat) begin
            errors++; $display("FAIL after_done: ack=%b load=%b cyc=%b rdat=%h exp 0 0 0 %h",
                               o_ack, o_load, o_wb_cyc, o_rdat, exp_rdat);
        end
    endtask

    task automatic run_misalign(input logic [1:0] size, input logic [31:0] adr);
        i_req = 1'b1; i_we = $urandom; i_size = size; i_adr = adr;
        tick;
        i_req = 1'b0;
        checks++;
        if (o_misalign !== 1'b1 || o_wb_cyc !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL misalign: mis=%b cyc=%b busy=%b exp 1 0 0", o_misalign, o_wb_cyc, o_busy);
        end
        tick;
        checks++;
        if (o_misalign !== 1'b0 || o_wb_cyc !== 1'b0 || o_ack !== 1'b0) begin
            errors++; $display("FAIL misalign_end: mis=%b cyc=%b ack=%b exp 0 0 0", o_misalign, o_wb_cyc, o_ack);
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        tick; tick;
        checks++;
        if (o_wb_adr !== 0 || o_wb_dat !== 0 || o_wb_sel !== 0 || o_wb_we !== 0 || o_wb_cyc !== 0 ||
            o_rdat !== 0 || o_load !== 0 || o_ack !== 0 || o_misalign !== 0 || o_err !== 0 || o_busy !== 0) begin
            errors++; $display("FAIL reset: adr=%h dat=%h sel=%b we=%b cyc=%b rdat=%h load=%b ack=%b mis=%b err=%b busy=%b",
                               o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_rdat, o_load, o_ack,
                               o_misalign, o_err, o_busy);
        end
        exp_rdat = '0;
        i_rst = 1'b0;
        tick;
    endtask

    task automatic test_directed;
        run_xfer(1'b0, 2'd2, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3);
        run_xfer(1'b1, 2'd0, 32'h0000_0203, 32'hAB00_0000, 32'h1234_5678, 1);
        run_misalign(2'd1, 32'h0000_0301);
        run_xfer(1'b0, 2'd1, 32'h0000_0302, 32'h0, 32'hCAFE_F00D, 0);
        run_misalign(2'd2, 32'h0000_0402);
        run_xfer(1'b0, 2'd3, 32'h0000_0500, 32'h0, 32'h0BAD_CAFE, 2);
    endtask

    task automatic test_idle_ack;
        i_wb_ack = 1'b1; i_wb_rdt = 32'h5555_AAAA;
        tick;
        i_wb_ack = 1'b0;
        tick;
        checks++;
        if (o_ack !== 1'b0 || o_load !== 1'b0 || o_rdat !== exp_rdat || o_wb_cyc !== 1'b0) begin
            errors++; $display("FAIL idle_ack: ack=%b load=%b rdat=%h cyc=%b exp 0 0 %h 0",
                               o_ack, o_load, o_rdat, o_wb_cyc, exp_rdat);
        end
    endtask

    task automatic test_back_to_back;
        i_req = 1'b1; i_we = 1'b0; i_size = 2'd2; i_adr = 32'h0000_0600;
        tick;
        checks++;
        if (o_wb_cyc !== 1'b1) begin errors++; $display("FAIL b2b_first: cyc=%b exp 1", o_wb_cyc); end
        i_wb_ack = 1'b1; i_wb_rdt = 32'h1111_2222;
        tick;
        i_wb_ack = 1'b0;
        exp_rdat = 32'h1111_2222;
        checks++;
        if (o_ack !== 1'b1 || o_wb_cyc !== 1'b0 || o_rdat !== exp_rdat) begin
            errors++; $display("FAIL b2b_done: ack=%b cyc=%b rdat=%h exp 1 0 %h", o_ack, o_wb_cyc, o_rdat, exp_rdat);
        end
        tick;
        i_req = 1'b0;
        checks++;
        if (o_wb_cyc !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL b2b_reissue: cyc=%b busy=%b exp 0 0", o_wb_cyc, o_busy);
        end
        tick;
        checks++;
        if (o_wb_cyc !== 1'b0) begin errors++; $display("FAIL b2b_gap: cyc=%b exp 0", o_wb_cyc); end
        run_xfer(1'b0, 2'd2, 32'h0000_0604, 32'h0, 32'h3333_4444, 1);
    endtask

    task automatic test_reset_mid;
        i_req = 1'b1; i_we = 1'b0; i_size = 2'd2; i_adr = 32'h0000_0700;
        tick;
        i_req = 1'b0;
        tick; tick;
        i_rst = 1'b1; i_wb_ack = 1'b1; i_wb_rdt = 32'h7777_7777;
        tick;
        exp_rdat = '0;
        checks++;
        if (o_wb_cyc !== 1'b0 || o_ack !== 1'b0 || o_load !== 1'b0 || o_err !== 1'b0 || o_rdat !== exp_rdat) begin
            errors++; $display("FAIL rst_mid: cyc=%b ack=%b load=%b err=%b rdat=%h exp 0 0 0 0 %h",
                               o_wb_cyc, o_ack, o_load, o_err, o_rdat, exp_rdat);
        end
        i_rst = 1'b0; i_wb_ack = 1'b0;
        tick;
        checks++;
        if (o_ack !== 1'b0 || o_load !== 1'b0 || o_wb_cyc !== 1'b0) begin
            errors++; $display("FAIL rst_mid_after: ack=%b load=%b cyc=%b exp 0 0 0", o_ack, o_load, o_wb_cyc);
        end
        run_xfer(1'b0, 2'd2, 32'h0000_0704, 32'h0, 32'h8888_9999, 2);
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            bit          we;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            we = 1'($urandom);
            if (ref_mis(sz, a)) run_misalign(sz, a);
            else run_xfer(we, sz, a, $urandom, $urandom, $urandom_range(0, 4));
        end
    endtask

`ifdef SERV_DBUS_TIMEOUT_EN
    task automatic test_timeout;
        i_req = 1'b1; i_we = 1'b0; i_size = 2'd2; i_adr = 32'h0000_0800;
        tick;
        i_req = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick;
            checks++;
            if (o_wb_cyc !== 1'b1 || o_err !== 1'b0) begin
                errors++; $display("FAIL to_wait: cyc=%b err=%b exp 1 0 at %0d", o_wb_cyc, o_err, k);
            end
        end
        tick;
        checks++;
        if (o_wb_cyc !== 1'b0 || o_err !== 1'b1 || o_ack !== 1'b1 || o_load !== 1'b0 || o_rdat !== exp_rdat) begin
            errors++; $display("FAIL to_abort: cyc=%b err=%b ack=%b load=%b rdat=%h exp 0 1 1 0 %h",
                               o_wb_cyc, o_err, o_ack, o_load, o_rdat, exp_rdat);
        end
        tick;
        checks++;
        if (o_err !== 1'b0 || o_ack !== 1'b0) begin
            errors++; $display("FAIL to_pulse: err=%b ack=%b exp 0 0", o_err, o_ack);
        end
        // Ack arriving in the last allowed cycle completes normally
        run_xfer(1'b0, 2'd2, 32'h0000_0804, 32'h0, 32'hFEED_FACE, 7);
    endtask
`endif

    initial begin
        test_reset;
        test_directed;
        test_idle_ack;
        test_back_to_back;
        test_reset_mid;
        test_random;
`ifdef SERV_DBUS_TIMEOUT_EN
        test_timeout;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
